proc_core_param: RTL

- Parametrised successor to the team's 9-bit multicycle teaching processor.
- Generalises data width and register-file depth, and adds logic ops (and/or/xor) and a conditional move (mvnz).
- Keeps the Run/Done instruction handshake, with instructions and immediates supplied on DIN.
- Sits between the instruction source (memory/testbench driving DIN) and the debug/display logic, which reads registers through a debug port.

---
 rtl/proc_core_param.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/proc_core_param.sv
// proc_core_param: parametrised multicycle processor (mv, mvi, add, sub, and, or, xor, mvnz).
// Define PROC_CORE_FLAGS_EN to register Z/C flags on ALU ops and drive the mvnz condition from Z.
module proc_core_param #(
    parameter int DW   = 9,
    parameter int NREG = 8,
    localparam int RW  = $clog2(NREG)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Run,
    input  logic [DW-1:0] DIN,
    output logic [DW-1:0] Bus,
    output logic          Done,
    output logic [DW-1:0] reg_IR,
    output logic [DW-1:0] reg_A,
    output logic [DW-1:0] reg_G,
    input  logic [RW-1:0] Dbg_Sel,
    output logic [DW-1:0] Dbg_Data,
    output logic          Flag_Z,
    output logic          Flag_C
);

    // Handshake: Run is a request sampled only in T0, where DIN is taken as the
    // instruction; Done is high in the instruction's final step, and the
    // following cycle is T0 again, ready for the next request.
    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MVNZ = 3'b111;

    state_t        state_q, state_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] g_q, g_d;
    logic [DW-1:0] regs_q [NREG];
    logic [2:0]    op;
    logic [RW-1:0] rx, ry;
    logic          is_alu;
    logic          wr_en;
    logic          nz_cond;
    logic [DW-1:0] alu_res;

    assign op     = ir_q[DW-1 -: 3];
    assign rx     = ir_q[DW-4 -: RW];
    assign ry     = ir_q[DW-4-RW -: RW];
    assign is_alu = (op != OP_MV) && (op != OP_MVI) && (op != OP_MVNZ);

    assign reg_IR   = ir_q;
    assign reg_A    = a_q;
    assign reg_G    = g_q;
    assign Dbg_Data = regs_q[Dbg_Sel];

`ifdef PROC_CORE_FLAGS_EN
    logic          flag_z_q, flag_c_q;
    logic          alu_c;
    logic [DW:0]   sum_ext;

    assign sum_ext = {1'b0, a_q} + {1'b0, Bus};
    assign alu_c   = (op == OP_ADD) ? sum_ext[DW] :
                     (op == OP_SUB) ? (a_q < Bus) : 1'b0;
    assign nz_cond = ~flag_z_q;
    assign Flag_Z  = flag_z_q;
    assign Flag_C  = flag_c_q;
`else
    assign nz_cond = (g_q != '0);
    assign Flag_Z  = 1'b0;
    assign Flag_C  = 1'b0;
`endif

    always_comb begin
        Bus = '0;
        case (state_q)
            T1:      Bus = is_alu ? regs_q[rx] : ((op == OP_MVI) ? DIN : regs_q[ry]);
            T2:      Bus = regs_q[ry];
            T3:      Bus = g_q;
            default: Bus = '0;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a_q + Bus;
            OP_SUB:  alu_res = a_q - Bus;
            OP_AND:  alu_res = a_q & Bus;
            OP_OR:   alu_res = a_q | Bus;
            OP_XOR:  alu_res = a_q ^ Bus;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        a_d     = a_q;
        g_d     = g_q;
        Done    = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            T0: begin
                if (Run) begin
                    ir_d    = DIN;
                    state_d = T1;
                end
            end
            T1: begin
                if (is_alu) begin
                    a_d     = Bus;
                    state_d = T2;
                end else begin
                    wr_en   = (op != OP_MVNZ) || nz_cond;
                    Done    = 1'b1;
                    state_d = T0;
                end
            end
            T2: begin
                g_d     = alu_res;
                state_d = T3;
            end
            T3: begin
                wr_en   = 1'b1;
                Done    = 1'b1;
                state_d = T0;
            end
            default: state_d = T0;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= T0;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
`ifdef PROC_CORE_FLAGS_EN
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            g_q     <= g_d;
            if (wr_en) regs_q[rx] <= Bus;
`ifdef PROC_CORE_FLAGS_EN
            // Flags follow the ALU result at the same edge that loads G.
            if (state_q == T2) begin
                flag_z_q <= (alu_res == '0);
                flag_c_q <= alu_c;
            end
`endif
        end
    end

endmodule
